// File: rtl/blk_3c5e6f.sv
// BCAM MBIST compare response handler: aligns the expected result with the array
// match vector, classifies each compare and keeps sticky/count/first-fail status.
module blk_3c5e6f #(
  parameter int RF_ENTRIES = 192,
  parameter int CM_LATENCY = 1,
  parameter int FAIL_CNT_W = 8,
  localparam int ENTRY_AW = $clog2(RF_ENTRIES)
) (
  input  logic                  bist_clk,
  input  logic                  bist_rst,
  input  logic                  BIST_CM_MODE_RF_IN,
  input  logic                  BIST_CM_EN_RF_IN,
  input  logic                  BIST_EXP_HIT_RF_IN,
  input  logic [ENTRY_AW-1:0]   BIST_EXP_ADDR_RF_IN,
  input  logic                  BIST_CLR_RF_IN,
  input  logic [RF_ENTRIES-1:0] CM_MATCH_RF_IN,
  output logic                  BIST_CM_RESULT_VALID_RF_OUT,
  output logic                  BIST_CM_PASS_RF_OUT,
  output logic                  BIST_CM_FAIL_RF_OUT,
  output logic [2:0]            BIST_CM_FAIL_CODE_RF_OUT,
  output logic                  BIST_CM_STICKY_FAIL_RF_OUT,
  output logic [FAIL_CNT_W-1:0] BIST_CM_FAIL_CNT_RF_OUT,
  output logic [ENTRY_AW-1:0]   BIST_CM_FIRST_FAIL_ADDR_RF_OUT,
  output logic [2:0]            BIST_CM_FIRST_FAIL_CODE_RF_OUT
);

  localparam logic [2:0] CODE_PASS      = 3'b000;
  localparam logic [2:0] CODE_MISS      = 3'b001;
  localparam logic [2:0] CODE_WRONG     = 3'b010;
  localparam logic [2:0] CODE_MULTI     = 3'b011;
  localparam logic [2:0] CODE_FALSE_HIT = 3'b100;

  localparam logic [ENTRY_AW:0] ENTRY_LIMIT = (ENTRY_AW+1)'(RF_ENTRIES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } state_t;

  state_t state;

  logic                accept;
  logic [CM_LATENCY-1:0] pipe_vld;
  logic                pipe_hit  [CM_LATENCY];
  logic [ENTRY_AW-1:0] pipe_addr [CM_LATENCY];
  logic                pipe_empty;

  logic                cls_vld;
  logic                cls_hit;
  logic [ENTRY_AW-1:0] cls_addr;
  logic                addr_ok;
  logic                addr_bit;
  logic                any_set;
  logic [RF_ENTRIES-1:0] exp_vec;
  logic [2:0]          cls_code;
  logic                res_fail;

  logic [FAIL_CNT_W-1:0] cnt_base;
  logic [FAIL_CNT_W-1:0] cnt_next;

  assign accept     = BIST_CM_EN_RF_IN & BIST_CM_MODE_RF_IN;
  assign pipe_empty = ~|pipe_vld;

  // Expected-result shift pipe, matching the array's compare latency.
  always_ff @(posedge bist_clk) begin
    if (bist_rst) begin
      for (int i = 0; i < CM_LATENCY; i++) begin
        pipe_vld[i]  <= 1'b0;
        pipe_hit[i]  <= 1'b0;
        pipe_addr[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= accept;
      pipe_hit[0]  <= BIST_EXP_HIT_RF_IN;
      pipe_addr[0] <= BIST_EXP_ADDR_RF_IN;
      for (int i = 1; i < CM_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_hit[i]  <= pipe_hit[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  assign cls_vld  = pipe_vld[CM_LATENCY-1];
  assign cls_hit  = pipe_hit[CM_LATENCY-1];
  assign cls_addr = pipe_addr[CM_LATENCY-1];
  assign addr_ok  = {1'b0, cls_addr} < ENTRY_LIMIT;
  assign any_set  = |CM_MATCH_RF_IN;

  // Out-of-range expected addresses yield an all-zero onehot and a zero match bit.
  always_comb begin
    exp_vec  = '0;
    addr_bit = 1'b0;
    if (addr_ok) begin
      addr_bit = CM_MATCH_RF_IN[cls_addr];
      if (cls_hit) begin
        exp_vec[cls_addr] = 1'b1;
      end
    end
  end

  always_comb begin
    cls_code = CODE_PASS;
    if (cls_hit) begin
      if (!any_set) begin
        cls_code = CODE_MISS;
      end else if (CM_MATCH_RF_IN == exp_vec) begin
        cls_code = CODE_PASS;
      end else if (!addr_bit) begin
        cls_code = CODE_WRONG;
      end else begin
        cls_code = CODE_MULTI;
      end
    end else if (any_set) begin
      cls_code = CODE_FALSE_HIT;
    end
  end

  assign res_fail = cls_vld && (cls_code != CODE_PASS);
  assign cnt_base = BIST_CLR_RF_IN ? '0 : BIST_CM_FAIL_CNT_RF_OUT;
  assign cnt_next = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;

  // Control FSM plus registered strobes and status; a clear lands before a coincident fail.
  always_ff @(posedge bist_clk) begin
    if (bist_rst) begin
      state                          <= ST_IDLE;
      BIST_CM_RESULT_VALID_RF_OUT    <= 1'b0;
      BIST_CM_PASS_RF_OUT            <= 1'b0;
      BIST_CM_FAIL_RF_OUT            <= 1'b0;
      BIST_CM_FAIL_CODE_RF_OUT       <= '0;
      BIST_CM_STICKY_FAIL_RF_OUT     <= 1'b0;
      BIST_CM_FAIL_CNT_RF_OUT        <= '0;
      BIST_CM_FIRST_FAIL_ADDR_RF_OUT <= '0;
      BIST_CM_FIRST_FAIL_CODE_RF_OUT <= '0;
    end else begin
      BIST_CM_RESULT_VALID_RF_OUT <= cls_vld;
      BIST_CM_PASS_RF_OUT         <= cls_vld && (cls_code == CODE_PASS);
      BIST_CM_FAIL_RF_OUT         <= res_fail;
      BIST_CM_FAIL_CODE_RF_OUT    <= cls_vld ? cls_code : CODE_PASS;

      case (state)
        ST_IDLE: begin
          if (BIST_CM_MODE_RF_IN) begin
            state <= ST_RUN;
          end
        end
        default: begin
          if (BIST_CLR_RF_IN) begin
            BIST_CM_STICKY_FAIL_RF_OUT     <= 1'b0;
            BIST_CM_FAIL_CNT_RF_OUT        <= '0;
            BIST_CM_FIRST_FAIL_ADDR_RF_OUT <= '0;
            BIST_CM_FIRST_FAIL_CODE_RF_OUT <= '0;
          end
          if (res_fail) begin
            BIST_CM_STICKY_FAIL_RF_OUT <= 1'b1;
            BIST_CM_FAIL_CNT_RF_OUT    <= cnt_next;
            if (BIST_CLR_RF_IN || !BIST_CM_STICKY_FAIL_RF_OUT) begin
              BIST_CM_FIRST_FAIL_ADDR_RF_OUT <= cls_addr;
              BIST_CM_FIRST_FAIL_CODE_RF_OUT <= cls_code;
            end
            state <= ST_FAIL;
          end else if (!BIST_CM_MODE_RF_IN && pipe_empty) begin
            state <= ST_IDLE;
          end else if (BIST_CLR_RF_IN) begin
            state <= ST_RUN;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blk_3c5e6f.sv
// Directed bench for the BCAM MBIST compare response handler (compare latency 2).
module tb_blk_3c5e6f;

  logic         bist_clk;
  logic         bist_rst;
  logic         mode;
  logic         en;
  logic         exp_hit;
  logic [7:0]   exp_addr;
  logic         clr;
  logic [191:0] match;
  logic         res_valid;
  logic         res_pass;
  logic         res_fail;
  logic [2:0]   res_code;
  logic         sticky;
  logic [7:0]   fail_cnt;
  logic [7:0]   ff_addr;
  logic [2:0]   ff_code;

  int vectors = 0;
  int miscompares = 0;

  blk_3c5e6f #(
    .RF_ENTRIES(192),
    .CM_LATENCY(2),
    .FAIL_CNT_W(8)
  ) dut (
    .bist_clk                      (bist_clk),
    .bist_rst                      (bist_rst),
    .BIST_CM_MODE_RF_IN            (mode),
    .BIST_CM_EN_RF_IN              (en),
    .BIST_EXP_HIT_RF_IN            (exp_hit),
    .BIST_EXP_ADDR_RF_IN           (exp_addr),
    .BIST_CLR_RF_IN                (clr),
    .CM_MATCH_RF_IN                (match),
    .BIST_CM_RESULT_VALID_RF_OUT   (res_valid),
    .BIST_CM_PASS_RF_OUT           (res_pass),
    .BIST_CM_FAIL_RF_OUT           (res_fail),
    .BIST_CM_FAIL_CODE_RF_OUT      (res_code),
    .BIST_CM_STICKY_FAIL_RF_OUT    (sticky),
    .BIST_CM_FAIL_CNT_RF_OUT       (fail_cnt),
    .BIST_CM_FIRST_FAIL_ADDR_RF_OUT(ff_addr),
    .BIST_CM_FIRST_FAIL_CODE_RF_OUT(ff_code)
  );

  initial bist_clk = 1'b0;
  always #5 bist_clk = ~bist_clk;

  function automatic logic [191:0] oh(input int a);
    logic [191:0] v;
    v = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge bist_clk);
    #1;
  endtask

  task automatic do_reset();
    bist_rst = 1'b1;
    mode = 1'b0; en = 1'b0; exp_hit = 1'b0; exp_addr = '0; clr = 1'b0; match = '0;
    tick();
    bist_rst = 1'b0;
  endtask

  task automatic issue(input logic h, input logic [7:0] a);
    en = 1'b1; exp_hit = h; exp_addr = a;
  endtask

  task automatic test_reset();
    bist_rst = 1'b1;
    mode = 1'b1; en = 1'b1; exp_hit = 1'b1; exp_addr = 8'd3; clr = 1'b0; match = '1;
    tick(); tick();
    vectors++;
    if ({res_valid, res_pass, res_fail, res_code, sticky, fail_cnt, ff_addr, ff_code} !== 26'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {res_valid, res_pass, res_fail, res_code, sticky, fail_cnt, ff_addr, ff_code});
    end
    vectors++;
    if (dut.state !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got %0d expected 0", dut.state);
    end
    bist_rst = 1'b0; en = 1'b0; mode = 1'b0; match = '0;
  endtask

  task automatic test_single_pass();
    do_reset();
    mode = 1'b1; issue(1'b1, 8'd37);
    tick(); en = 1'b0;
    tick(); match = oh(37);
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_early_valid: got %0b expected 0", res_valid);
    end
    tick(); match = '0;
    vectors++;
    if ({res_valid, res_pass, res_fail, res_code, sticky, fail_cnt} !== {3'b110, 3'b000, 1'b0, 8'd0}) begin
      miscompares++;
      $display("[TB] FAIL single_pass: got v%0b p%0b f%0b c%0d s%0b n%0d expected v1 p1 f0 c0 s0 n0",
               res_valid, res_pass, res_fail, res_code, sticky, fail_cnt);
    end
    tick();
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_strobe_width: got %0b expected 0", res_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_codes [4];
    exp_codes[0] = 3'b000; exp_codes[1] = 3'b001; exp_codes[2] = 3'b011; exp_codes[3] = 3'b100;
    do_reset();
    mode = 1'b1;
    for (int c = 0; c < 7; c++) begin
      en = 1'b0; match = '0;
      case (c)
        0: issue(1'b1, 8'd10);
        1: issue(1'b1, 8'd20);
        2: begin issue(1'b1, 8'd5); match = oh(10); end
        3: issue(1'b0, 8'd0);
        4: match = oh(5) | oh(9);
        5: match = oh(191);
        default: ;
      endcase
      if (c >= 3) begin
        vectors++;
        if ({res_valid, res_pass, res_fail, res_code} !==
            {1'b1, exp_codes[c-3] == 3'b000, exp_codes[c-3] != 3'b000, exp_codes[c-3]}) begin
          miscompares++;
          $display("[TB] FAIL b2b_result%0d: got v%0b p%0b f%0b c%0d expected code %0d",
                   c - 3, res_valid, res_pass, res_fail, res_code, exp_codes[c-3]);
        end
      end
      tick();
    end
    en = 1'b0; match = '0;
    // Status as seen in the cycle after the last strobe.
    vectors++;
    if ({sticky, fail_cnt, ff_addr, ff_code} !== {1'b1, 8'd3, 8'd20, 3'b001}) begin
      miscompares++;
      $display("[TB] FAIL b2b_status: got s%0b n%0d a%0d c%0d expected s1 n3 a20 c1",
               sticky, fail_cnt, ff_addr, ff_code);
    end
    vectors++;
    if (dut.state !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL b2b_state: got %0d expected 2", dut.state);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    mode = 1'b1; match = oh(4);
    for (int c = 0; c < 303; c++) begin
      if (c < 300) issue(1'b1, (c == 0) ? 8'd3 : 8'd7);
      else en = 1'b0;
      if (c == 12) begin
        vectors++;
        if ({res_fail, res_code, fail_cnt} !== {1'b1, 3'b010, 8'd10}) begin
          miscompares++;
          $display("[TB] FAIL sat_midcount: got f%0b c%0d n%0d expected f1 c2 n10", res_fail, res_code, fail_cnt);
        end
      end
      tick();
    end
    en = 1'b0; match = '0;
    vectors++;
    if ({sticky, fail_cnt, ff_addr, ff_code} !== {1'b1, 8'd255, 8'd3, 3'b010}) begin
      miscompares++;
      $display("[TB] FAIL sat_final: got s%0b n%0d a%0d c%0d expected s1 n255 a3 c2",
               sticky, fail_cnt, ff_addr, ff_code);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    mode = 1'b1;
    issue(1'b1, 8'd200);
    tick(); issue(1'b1, 8'd250);
    tick(); en = 1'b0; match = '0;
    tick(); match = oh(5);
    vectors++;
    if ({res_valid, res_code} !== {1'b1, 3'b001}) begin
      miscompares++;
      $display("[TB] FAIL oor_miss: got v%0b c%0d expected v1 c1", res_valid, res_code);
    end
    tick(); match = '0;
    vectors++;
    if ({res_valid, res_fail, res_code, ff_addr, fail_cnt} !== {2'b11, 3'b010, 8'd200, 8'd2}) begin
      miscompares++;
      $display("[TB] FAIL oor_wrong: got v%0b f%0b c%0d a%0d n%0d expected v1 f1 c2 a200 n2",
               res_valid, res_fail, res_code, ff_addr, fail_cnt);
    end
  endtask

  task automatic test_clear();
    do_reset();
    mode = 1'b1;
    issue(1'b1, 8'd8);
    tick(); issue(1'b0, 8'd77);
    tick(); en = 1'b0;
    tick(); match = oh(50); clr = 1'b1;
    vectors++;
    if ({res_code, fail_cnt, ff_code, ff_addr} !== {3'b001, 8'd1, 3'b001, 8'd8}) begin
      miscompares++;
      $display("[TB] FAIL clr_pre: got c%0d n%0d fc%0d fa%0d expected c1 n1 fc1 fa8",
               res_code, fail_cnt, ff_code, ff_addr);
    end
    tick(); match = '0; clr = 1'b0;
    vectors++;
    if ({res_fail, res_code, sticky, fail_cnt, ff_code, ff_addr} !== {1'b1, 3'b100, 1'b1, 8'd1, 3'b100, 8'd77}) begin
      miscompares++;
      $display("[TB] FAIL clr_with_fail: got f%0b c%0d s%0b n%0d fc%0d fa%0d expected f1 c4 s1 n1 fc4 fa77",
               res_fail, res_code, sticky, fail_cnt, ff_code, ff_addr);
    end
    clr = 1'b1;
    tick(); clr = 1'b0;
    vectors++;
    if ({sticky, fail_cnt, ff_code, ff_addr} !== 20'd0) begin
      miscompares++;
      $display("[TB] FAIL clr_alone: got s%0b n%0d fc%0d fa%0d expected all 0", sticky, fail_cnt, ff_code, ff_addr);
    end
    vectors++;
    if (dut.state !== 2'd1) begin
      miscompares++;
      $display("[TB] FAIL clr_state: got %0d expected 1", dut.state);
    end
  endtask

  task automatic test_mode_drop();
    do_reset();
    mode = 1'b1; issue(1'b1, 8'd12);
    tick(); en = 1'b0; mode = 1'b0;
    tick(); match = oh(12);
    tick(); match = '0;
    vectors++;
    if ({res_valid, res_pass} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL drop_drain: got v%0b p%0b expected v1 p1", res_valid, res_pass);
    end
    tick();
    vectors++;
    if (dut.state !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL drop_idle: got %0d expected 0", dut.state);
    end
    issue(1'b1, 8'd12);
    tick(); en = 1'b0;
    tick(); match = oh(3);
    tick(); match = '0;
    vectors++;
    if ({res_valid, res_pass, res_fail, sticky} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL en_no_mode: got v%0b p%0b f%0b s%0b expected all 0", res_valid, res_pass, res_fail, sticky);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    mode = 1'b1; issue(1'b1, 8'd9);
    tick(); en = 1'b0;
    tick();
    tick(); issue(1'b1, 8'd40);
    vectors++;
    if ({res_fail, fail_cnt} !== {1'b1, 8'd1}) begin
      miscompares++;
      $display("[TB] FAIL rstmid_pre: got f%0b n%0d expected f1 n1", res_fail, fail_cnt);
    end
    tick(); en = 1'b0; bist_rst = 1'b1;
    tick(); bist_rst = 1'b0; mode = 1'b0; match = oh(40);
    vectors++;
    if ({sticky, fail_cnt, ff_addr, ff_code} !== 20'd0 || dut.state !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL rstmid_status: got s%0b n%0d a%0d c%0d st%0d expected all 0",
               sticky, fail_cnt, ff_addr, ff_code, dut.state);
    end
    tick(); match = '0;
    vectors++;
    if ({res_valid, res_pass, res_fail} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL rstmid_strobe: got v%0b p%0b f%0b expected 0", res_valid, res_pass, res_fail);
    end
  endtask

  initial begin
    bist_rst = 1'b1;
    mode = 1'b0; en = 1'b0; exp_hit = 1'b0; exp_addr = '0; clr = 1'b0; match = '0;
    test_reset();
    test_single_pass();
    test_back_to_back();
    test_saturate();
    test_out_of_range();
    test_clear();
    test_mode_drop();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
